// File: rtl/cruise_pkg.sv
// Shared mode command codes, FSM state encoding and default tuning values
// for the cruise sequencer.
package cruise_pkg;

    localparam logic [1:0] MODE_HOLD    = 2'b00;
    localparam logic [1:0] MODE_CMP     = 2'b01;
    localparam logic [1:0] MODE_CAPTURE = 2'b10;
    localparam logic [1:0] MODE_STEP    = 2'b11;

    localparam logic [7:0] DEF_MIN_SPEED       = 8'd30;
    localparam logic [7:0] DEF_MAX_SPEED       = 8'd180;
    localparam int         DEF_REPEAT_CYCLES   = 16;
    localparam int         DEF_SUSPEND_TIMEOUT = 1024;

    typedef enum logic [2:0] {
        OFF       = 3'd0,
        CAPTURE   = 3'd1,
        ACTIVE    = 3'd2,
        STEP      = 3'd3,
        SUSPENDED = 3'd4
    } state_t;

    function automatic logic [1:0] mode_of(input state_t s);
        case (s)
            CAPTURE: mode_of = MODE_CAPTURE;
            ACTIVE:  mode_of = MODE_CMP;
            STEP:    mode_of = MODE_STEP;
            default: mode_of = MODE_HOLD;
        endcase
    endfunction

endpackage

// File: rtl/cruise_btn_edge.sv
// Rising-edge detector for a debounced button; the armed flag suppresses a
// spurious edge from a button that was already held while reset was applied.
module cruise_btn_edge (
    input  logic clk,
    input  logic clear,
    input  logic btn,
    output logic rise
);

    logic prev;
    logic armed;

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            prev  <= 1'b0;
            armed <= 1'b0;
        end else begin
            prev  <= btn;
            armed <= 1'b1;
        end
    end

    assign rise = armed & btn & ~prev;

endmodule

// File: rtl/cruise_sequencer.sv
// Driver-facing cruise control sequencer: arbitrates buttons and the safety
// brake into registered mode/step commands, with auto-repeat and suspend timeout.
module cruise_sequencer
    import cruise_pkg::*;
#(
    parameter logic [7:0] MIN_SPEED       = DEF_MIN_SPEED,
    parameter logic [7:0] MAX_SPEED       = DEF_MAX_SPEED,
    parameter int         REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
    parameter int         SUSPEND_TIMEOUT = DEF_SUSPEND_TIMEOUT
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       btn_set,
    input  logic       btn_resume,
    input  logic       btn_cancel,
    input  logic       btn_off,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       brake,
    input  logic [7:0] current_speed,
    input  logic [7:0] default_speed,
    output logic [1:0] mode,
    output logic       step_dir,
    output logic       engaged,
    output logic [2:0] state_out
);

    localparam int REP_W = $clog2(REPEAT_CYCLES);
    localparam int TO_W  = $clog2(SUSPEND_TIMEOUT);
    localparam logic [REP_W-1:0] REP_LOAD = REP_W'(REPEAT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(SUSPEND_TIMEOUT - 1);

    state_t            state;
    state_t            next_state;
    logic [REP_W-1:0]  rep_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic              set_rise;
    logic              resume_rise;
    logic              cancel_rise;
    logic              set_ok;
    logic              held;
    logic              req_dir;
    logic              step_ok;

    cruise_btn_edge u_set_edge    (.clk(clk), .clear(clear), .btn(btn_set),    .rise(set_rise));
    cruise_btn_edge u_resume_edge (.clk(clk), .clear(clear), .btn(btn_resume), .rise(resume_rise));
    cruise_btn_edge u_cancel_edge (.clk(clk), .clear(clear), .btn(btn_cancel), .rise(cancel_rise));

    // Up beats down; a direction change bypasses the repeat delay.
    always_comb begin
        set_ok  = set_rise && (current_speed >= MIN_SPEED) && (current_speed <= MAX_SPEED);
        held    = btn_up | btn_down;
        req_dir = btn_up;
        step_ok = held && ((rep_cnt == '0) || (req_dir != step_dir)) &&
                  (req_dir ? (default_speed < MAX_SPEED) : (default_speed > MIN_SPEED));
    end

    always_comb begin
        next_state = state;
        if (btn_off) begin
            next_state = OFF;
        end else begin
            case (state)
                OFF: begin
                    if (!brake && !cancel_rise && set_ok)
                        next_state = CAPTURE;
                end
                CAPTURE: begin
                    next_state = brake ? SUSPENDED : ACTIVE;
                end
                ACTIVE: begin
                    if (brake || cancel_rise)
                        next_state = SUSPENDED;
                    else if (set_ok)
                        next_state = CAPTURE;
                    else if (step_ok)
                        next_state = STEP;
                end
                STEP: begin
                    next_state = (brake || cancel_rise) ? SUSPENDED : ACTIVE;
                end
                SUSPENDED: begin
                    if (to_cnt == TO_LAST)
                        next_state = OFF;
                    else if (!brake && !cancel_rise) begin
                        if (set_ok)
                            next_state = CAPTURE;
                        else if (resume_rise && (default_speed >= MIN_SPEED))
                            next_state = ACTIVE;
                    end
                end
                default: next_state = OFF;
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state    <= OFF;
            mode     <= MODE_HOLD;
            engaged  <= 1'b0;
            step_dir <= 1'b0;
        end else begin
            state   <= next_state;
            mode    <= mode_of(next_state);
            engaged <= (next_state == ACTIVE) || (next_state == STEP);
            if (next_state == STEP)
                step_dir <= req_dir;
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            rep_cnt <= '0;
            to_cnt  <= '0;
        end else begin
            if (next_state == STEP)
                rep_cnt <= REP_LOAD;
            else if (((state == ACTIVE) || (state == STEP)) && held && (req_dir == step_dir)) begin
                if (rep_cnt != '0)
                    rep_cnt <= rep_cnt - 1'b1;
            end else
                rep_cnt <= '0;

            if ((state == SUSPENDED) && (next_state == SUSPENDED)) begin
                if (to_cnt != TO_LAST)
                    to_cnt <= to_cnt + 1'b1;
            end else
                to_cnt <= '0;
        end
    end

    assign state_out = state;

endmodule

// File: tb/tb_cruise_sequencer.sv
// Self-checking bench for cruise_sequencer: a directed vector table followed by
// hand-written auto-repeat, limit, timeout and asynchronous-clear sequences.
module tb_cruise_sequencer;

    logic       clk = 1'b0;
    logic       clear;
    logic       btn_set, btn_resume, btn_cancel, btn_off, btn_up, btn_down, brake;
    logic [7:0] current_speed, default_speed;
    logic [1:0] mode;
    logic       step_dir, engaged;
    logic [2:0] state_out;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string      name;
        logic [6:0] btns;
        logic [7:0] cur;
        logic [7:0] dflt;
        logic [1:0] exp_mode;
        logic       exp_eng;
        logic [2:0] exp_state;
        logic       chk_dir;
        logic       exp_dir;
    } vec_t;

    vec_t vecs[$];

    cruise_sequencer dut (
        .clk(clk), .clear(clear),
        .btn_set(btn_set), .btn_resume(btn_resume), .btn_cancel(btn_cancel),
        .btn_off(btn_off), .btn_up(btn_up), .btn_down(btn_down), .brake(brake),
        .current_speed(current_speed), .default_speed(default_speed),
        .mode(mode), .step_dir(step_dir), .engaged(engaged), .state_out(state_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Button bit order: off, brake, cancel, set, resume, up, down.
    task automatic applyStimulus(input logic [6:0] b, input logic [7:0] cur, input logic [7:0] dflt);
        {btn_off, brake, btn_cancel, btn_set, btn_resume, btn_up, btn_down} = b;
        current_speed = cur;
        default_speed = dflt;
    endtask

    task automatic checkOutput(input string name, input logic [1:0] em, input logic ee, input logic [2:0] es);
        checks++;
        if (mode !== em || engaged !== ee || state_out !== es) begin
            failures++;
            $display("[TB] FAIL %s: got mode=%b engaged=%b state=%0d, expected mode=%b engaged=%b state=%0d",
                     name, mode, engaged, state_out, em, ee, es);
        end
    endtask

    task automatic checkDir(input string name, input logic ed);
        checks++;
        if (step_dir !== ed) begin
            failures++;
            $display("[TB] FAIL %s: got step_dir=%b, expected %b", name, step_dir, ed);
        end
    endtask

    task automatic addVec(input string n, input logic [6:0] b, input logic [7:0] cur, input logic [7:0] dflt,
                          input logic [1:0] em, input logic ee, input logic [2:0] es,
                          input logic cd, input logic ed);
        vec_t v;
        v.name = n; v.btns = b; v.cur = cur; v.dflt = dflt;
        v.exp_mode = em; v.exp_eng = ee; v.exp_state = es; v.chk_dir = cd; v.exp_dir = ed;
        vecs.push_back(v);
    endtask

    initial begin
        //      name            off/brk/can/set/res/up/dn  cur  dflt  mode  eng st  dir?
        addVec("idle_off",      7'b0000000, 8'd60, 8'd100, 2'b00, 0, 0, 0, 0);
        addVec("set_low",       7'b0001000, 8'd20, 8'd100, 2'b00, 0, 0, 0, 0);
        addVec("set_low_rel",   7'b0000000, 8'd20, 8'd100, 2'b00, 0, 0, 0, 0);
        addVec("set_capture",   7'b0001000, 8'd60, 8'd100, 2'b10, 0, 1, 0, 0);
        addVec("to_active",     7'b0001000, 8'd60, 8'd100, 2'b01, 1, 2, 0, 0);
        addVec("set_held",      7'b0001000, 8'd60, 8'd100, 2'b01, 1, 2, 0, 0);
        addVec("brake_susp",    7'b0100000, 8'd60, 8'd100, 2'b00, 0, 4, 0, 0);
        addVec("brake_resume",  7'b0100100, 8'd60, 8'd100, 2'b00, 0, 4, 0, 0);
        addVec("resume_held",   7'b0000100, 8'd60, 8'd100, 2'b00, 0, 4, 0, 0);
        addVec("resume_rel",    7'b0000000, 8'd60, 8'd100, 2'b00, 0, 4, 0, 0);
        addVec("resume_edge",   7'b0000100, 8'd60, 8'd100, 2'b01, 1, 2, 0, 0);
        addVec("brk_can_up",    7'b0110010, 8'd60, 8'd100, 2'b00, 0, 4, 0, 0);
        addVec("combo_rel",     7'b0000000, 8'd60, 8'd100, 2'b00, 0, 4, 0, 0);
        addVec("set_in_susp",   7'b0001000, 8'd60, 8'd100, 2'b10, 0, 1, 0, 0);
        addVec("cap_done",      7'b0000000, 8'd60, 8'd100, 2'b01, 1, 2, 0, 0);
        addVec("down_step",     7'b0000001, 8'd60, 8'd100, 2'b11, 1, 3, 1, 0);
        addVec("down_back",     7'b0000001, 8'd60, 8'd100, 2'b01, 1, 2, 0, 0);
        addVec("dir_change",    7'b0000011, 8'd60, 8'd100, 2'b11, 1, 3, 1, 1);
        addVec("dir_release",   7'b0000000, 8'd60, 8'd100, 2'b01, 1, 2, 0, 0);
        addVec("cancel_susp",   7'b0010000, 8'd60, 8'd100, 2'b00, 0, 4, 0, 0);
        addVec("off_set_susp",  7'b1001000, 8'd60, 8'd100, 2'b00, 0, 0, 0, 0);
        addVec("idle_a",        7'b0000000, 8'd60, 8'd100, 2'b00, 0, 0, 0, 0);
        addVec("off_set_off",   7'b1001000, 8'd60, 8'd100, 2'b00, 0, 0, 0, 0);
        addVec("idle_b",        7'b0000000, 8'd60, 8'd100, 2'b00, 0, 0, 0, 0);
        addVec("set_cap2",      7'b0001000, 8'd60, 8'd100, 2'b10, 0, 1, 0, 0);
        addVec("off_in_cap",    7'b1001000, 8'd60, 8'd100, 2'b00, 0, 0, 0, 0);
        addVec("idle_c",        7'b0000000, 8'd60, 8'd100, 2'b00, 0, 0, 0, 0);
        addVec("set_cap3",      7'b0001000, 8'd60, 8'd100, 2'b10, 0, 1, 0, 0);
        addVec("active3",       7'b0000000, 8'd60, 8'd100, 2'b01, 1, 2, 0, 0);
        addVec("off_set_act",   7'b1001000, 8'd60, 8'd100, 2'b00, 0, 0, 0, 0);
        addVec("idle_d",        7'b0000000, 8'd60, 8'd100, 2'b00, 0, 0, 0, 0);
        addVec("set_cap4",      7'b0001000, 8'd60, 8'd100, 2'b10, 0, 1, 0, 0);
        addVec("active4",       7'b0000000, 8'd60, 8'd100, 2'b01, 1, 2, 0, 0);
        addVec("down_at_min",   7'b0000001, 8'd60, 8'd30,  2'b01, 1, 2, 0, 0);
        addVec("down_at_min2",  7'b0000001, 8'd60, 8'd30,  2'b01, 1, 2, 0, 0);
        addVec("min_release",   7'b0000000, 8'd60, 8'd30,  2'b01, 1, 2, 0, 0);
        addVec("cancel_susp2",  7'b0010000, 8'd60, 8'd100, 2'b00, 0, 4, 0, 0);
        addVec("resume_low",    7'b0000100, 8'd60, 8'd20,  2'b00, 0, 4, 0, 0);
        addVec("resume_low_rel",7'b0000000, 8'd60, 8'd100, 2'b00, 0, 4, 0, 0);

        // Reset with set held high throughout.
        applyStimulus(7'b0001000, 8'd60, 8'd100);
        clear = 1'b1;
        tick(); tick();
        checkOutput("reset_state", 2'b00, 1'b0, 3'd0);
        checkDir("reset_step_dir", 1'b0);
        clear = 1'b0;
        tick(); tick();
        checkOutput("set_held_through_reset", 2'b00, 1'b0, 3'd0);
        applyStimulus(7'b0000000, 8'd60, 8'd100);
        tick();

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].btns, vecs[i].cur, vecs[i].dflt);
            tick();
            checkOutput(vecs[i].name, vecs[i].exp_mode, vecs[i].exp_eng, vecs[i].exp_state);
            if (vecs[i].chk_dir)
                checkDir({vecs[i].name, "_dir"}, vecs[i].exp_dir);
        end

        // Auto-repeat: up held 40 cycles steps at cycles 1, 17 and 33.
        applyStimulus(7'b0000100, 8'd60, 8'd100);
        tick();
        checkOutput("rep_resume", 2'b01, 1'b1, 3'd2);
        applyStimulus(7'b0000010, 8'd60, 8'd100);
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (k == 1 || k == 17 || k == 33) begin
                checkOutput($sformatf("rep_step_%0d", k), 2'b11, 1'b1, 3'd3);
                checkDir($sformatf("rep_dir_%0d", k), 1'b1);
            end else
                checkOutput($sformatf("rep_wait_%0d", k), 2'b01, 1'b1, 3'd2);
        end
        applyStimulus(7'b0000000, 8'd60, 8'd100);
        tick();
        checkOutput("rep_release", 2'b01, 1'b1, 3'd2);

        // Up held at MAX_SPEED never steps.
        applyStimulus(7'b0000010, 8'd60, 8'd180);
        for (int k = 1; k <= 40; k++) begin
            tick();
            checkOutput($sformatf("max_hold_%0d", k), 2'b01, 1'b1, 3'd2);
        end
        applyStimulus(7'b0000000, 8'd60, 8'd100);
        tick();

        // Suspend timeout: brake held for a while, then released, OFF after 1024 cycles.
        applyStimulus(7'b0100000, 8'd60, 8'd100);
        tick();
        checkOutput("to_enter", 2'b00, 1'b0, 3'd4);
        for (int k = 1; k <= 1023; k++) begin
            if (k == 100)
                applyStimulus(7'b0000000, 8'd60, 8'd100);
            tick();
        end
        checkOutput("to_last_cycle", 2'b00, 1'b0, 3'd4);
        tick();
        checkOutput("to_off", 2'b00, 1'b0, 3'd0);

        // Asynchronous clear during CAPTURE.
        applyStimulus(7'b0001000, 8'd60, 8'd100);
        tick();
        checkOutput("clr_cap_pre", 2'b10, 1'b0, 3'd1);
        #2 clear = 1'b1;
        #1;
        checkOutput("clr_cap_async", 2'b00, 1'b0, 3'd0);
        tick();
        clear = 1'b0;
        applyStimulus(7'b0000000, 8'd60, 8'd100);
        tick(); tick();

        // Asynchronous clear during STEP.
        applyStimulus(7'b0001000, 8'd60, 8'd100);
        tick();
        applyStimulus(7'b0000000, 8'd60, 8'd100);
        tick();
        checkOutput("clr_step_active", 2'b01, 1'b1, 3'd2);
        applyStimulus(7'b0000010, 8'd60, 8'd100);
        tick();
        checkOutput("clr_step_pre", 2'b11, 1'b1, 3'd3);
        #2 clear = 1'b1;
        #1;
        checkOutput("clr_step_async", 2'b00, 1'b0, 3'd0);
        checkDir("clr_step_dir", 1'b0);
        tick();
        clear = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
